sync_frame_tx: RTL and testbench
================================

# sync_frame_tx

Serial frame transmitter that drives the single-bit line watched by the team's 1101 sequence detectors. On a start request it captures a parallel data word, then shifts out a 4-bit sync header (default 1101), the payload MSB-first, an even-parity bit, and one guard bit of 0. It sits on the transmit side of the serial test link, producing exactly the bit stream the detector block consumes: one bit per clock, with a start/busy/done handshake toward the host logic.

## Interface

Parameters:
- DATA_W, 8, payload width in bits; legal range 1..32.
- HEADER, 4'b1101, sync header, sent bit 3 first.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  frame request; sampled only while busy=0.
- data_in  input  DATA_W  payload; captured on the edge that accepts start.
- dout  output  1  serial line; registered.
- busy  output  1  high from the accept edge through the guard-bit cycle.
- done  output  1  one-cycle pulse during the guard-bit cycle.
- state  output  3  current FSM state, for debug; encoding IDLE=0, HDR=1, DATA=2, PAR=3, GAP=4.

## Operation

- Reset (reset_n=0, asynchronous): state=IDLE, dout=0, busy=0, done=0, shift register and counters cleared. Reset asserted mid-frame aborts the frame immediately; no partial-frame recovery.
- FSM is Moore. All outputs come from registers; no combinational path from start or data_in to any output.
- IDLE: dout=0. If start=1 at an edge:
  - load HEADER and data_in into the shift/counter logic;
  - compute parity = XOR of all data_in bits, registered;
  - go to HDR with busy=1 and dout=HEADER[3].
- HDR: 4 cycles, dout = HEADER[3], [2], [1], [0]. Then DATA.
- DATA: DATA_W cycles, dout = data[DATA_W-1] down to data[0]. Then PAR.
- PAR: 1 cycle, dout = parity. Even parity: the ones-count of data plus parity bit is even.
- GAP: 1 cycle, dout=0, done=1, busy=1. Then IDLE.
- start while busy=1 is ignored, not queued.
- data_in changes after the accept edge have no effect on the frame in flight.
- Bit counter width is ceil(log2(DATA_W))+1; it wraps only via explicit reload, never by overflow.
- Illegal state encodings (5..7) return to IDLE on the next edge with dout=0, busy=0, done=0.

## Timing

- Edge E0 accepts start. dout after each edge:
  - E0..E3: header bits;
  - E4..E(3+DATA_W): data bits;
  - E(4+DATA_W): parity;
  - E(5+DATA_W): 0, with done=1.
- At E(6+DATA_W): busy=0, done=0, state=IDLE.
- Frame occupies 6+DATA_W cycles (14 for DATA_W=8).
- Back-to-back: start held high is accepted at E(6+DATA_W), so the next header begins one cycle after the guard bit. Minimum spacing is 6+DATA_W cycles between accepts.
- Latency from the start edge to the first header bit on dout is 0 cycles: the bit is visible right after the accepting edge.

## Test plan

- Reset: reset_n=0 with start=1 and data toggling -> dout=0, busy=0, done=0, state=0 throughout; release reset_n -> nothing is sent until start is sampled.
- Single frame, DATA_W=8, data_in=8'hA5, one-cycle start pulse:
  - dout sequence 1,1,0,1, 1,0,1,0,0,1,0,1, 0(parity), 0(guard);
  - busy high for 14 cycles; done high only in cycle 14.
- Odd parity payload: data_in=8'h01 -> payload 00000001, parity bit=1. data_in=8'hFF -> parity 0.
- Ignored start and data stability: pulse start at cycles 3 and 9 of a frame and change data_in after E0 -> the frame is unchanged and no second frame follows.
- Back-to-back: start held high with data 8'hA5 then 8'h3C -> second header begins at E14. 8'h3C sends 00111100 with parity 0. No idle bit between frames beyond the guard 0.
- Mid-frame reset: assert reset_n=0 during DATA at cycle 6 -> dout=0, busy=0, done=0 immediately (before the next edge). A new start after release sends a complete fresh frame.

Source files
------------

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync header, MSB-first payload, even parity, guard 0.
// One bit per clock on a registered line, with a start/busy/done handshake.
module sync_frame_tx #(
  parameter int         DATA_W = 8,
  parameter logic [3:0] HEADER = 4'b1101
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              dout,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state
);

  // The header countdown needs to reach 3 even when DATA_W=1 would give a 1-bit counter.
  localparam int CNT_RAW = $clog2(DATA_W) + 1;
  localparam int CNT_W   = (CNT_RAW < 2) ? 2 : CNT_RAW;
  localparam int SR_W    = DATA_W + 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    PAR  = 3'd3,
    GAP  = 3'd4
  } state_t;

  state_t            state_q, state_nx;
  logic              dout_q, dout_nx;
  logic              busy_q, busy_nx;
  logic              done_q, done_nx;
  logic              par_q, par_nx;
  logic [SR_W-1:0]   sreg_q, sreg_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic              accept;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      par_q   <= 1'b0;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      dout_q  <= dout_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
      par_q   <= par_nx;
      sreg_q  <= sreg_nx;
      cnt_q   <= cnt_nx;
    end
  end

  // cnt_q holds the cycles remaining in the current state after this one;
  // sreg_q holds the bits still to be sent after the one now on dout.
  always_comb begin
    state_nx = state_q;
    dout_nx  = 1'b0;
    busy_nx  = busy_q;
    done_nx  = 1'b0;
    par_nx   = par_q;
    sreg_nx  = sreg_q;
    cnt_nx   = cnt_q;
    accept   = 1'b0;

    case (state_q)
      IDLE: begin
        busy_nx = 1'b0;
        accept  = start;
      end
      HDR: begin
        busy_nx = 1'b1;
        dout_nx = sreg_q[SR_W-1];
        sreg_nx = {sreg_q[SR_W-2:0], 1'b0};
        if (cnt_q != '0) begin
          cnt_nx = cnt_q - 1'b1;
        end else begin
          state_nx = DATA;
          cnt_nx   = CNT_W'(DATA_W - 1);
        end
      end
      DATA: begin
        busy_nx = 1'b1;
        if (cnt_q != '0) begin
          dout_nx = sreg_q[SR_W-1];
          sreg_nx = {sreg_q[SR_W-2:0], 1'b0};
          cnt_nx  = cnt_q - 1'b1;
        end else begin
          state_nx = PAR;
          dout_nx  = par_q;
        end
      end
      PAR: begin
        state_nx = GAP;
        busy_nx  = 1'b1;
        done_nx  = 1'b1;
      end
      GAP: begin
        // The guard cycle doubles as an accept slot so back-to-back frames abut.
        state_nx = IDLE;
        busy_nx  = 1'b0;
        accept   = start;
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase

    if (accept) begin
      state_nx = HDR;
      busy_nx  = 1'b1;
      dout_nx  = HEADER[3];
      sreg_nx  = {HEADER[2:0], data_in};
      cnt_nx   = CNT_W'(3);
      par_nx   = even_parity(data_in);
    end
  end

  assign dout  = dout_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx with hand-computed bit streams (DATA_W=8).
module tb_sync_frame_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] data_in;
  logic       dout;
  logic       busy;
  logic       done;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  sync_frame_tx #(.DATA_W(8), .HEADER(4'b1101)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .data_in (data_in),
    .dout    (dout),
    .busy    (busy),
    .done    (done),
    .state   (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_state(input int i);
    if (i < 4)       return 3'd1;
    else if (i < 12) return 3'd2;
    else if (i == 12) return 3'd3;
    else             return 3'd4;
  endfunction

  // Sends one frame; with poke set, start is pulsed during cycles 3 and 9 and data_in is scrambled.
  task automatic run_frame(input logic [7:0] d, input logic [13:0] exp, input bit poke);
    @(negedge clk);
    start   = 1'b1;
    data_in = d;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      chk("dout", dout, exp[13-i]);
      chk("busy", busy, 1'b1);
      chk("done", done, (i == 13));
      chk("state", state, exp_state(i));
      if (poke) begin
        data_in = ~data_in;
        start   = (i == 2 || i == 8);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("idle_busy", busy, 1'b0);
      chk("idle_dout", dout, 1'b0);
      chk("idle_state", state, 3'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [27:0] b2b;
    reset_n = 1'b0;
    start   = 1'b1;
    data_in = 8'h00;

    // Held in reset with start asserted and data toggling.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      data_in = data_in ^ 8'hFF;
      chk("rst_dout", dout, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_state", state, 3'd0);
    end
    @(negedge clk);
    start   = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_dout", dout, 1'b0);
    end

    run_frame(8'hA5, 14'b1101_10100101_0_0, 1'b0);
    run_frame(8'h01, 14'b1101_00000001_1_0, 1'b0);
    run_frame(8'hFF, 14'b1101_11111111_0_0, 1'b0);
    run_frame(8'hA5, 14'b1101_10100101_0_0, 1'b1);

    // Back-to-back: start held high across the guard cycle.
    b2b = {14'b1101_10100101_0_0, 14'b1101_00111100_0_0};
    @(negedge clk);
    start   = 1'b1;
    data_in = 8'hA5;
    @(posedge clk); #1;
    data_in = 8'h3C;
    for (int i = 0; i < 28; i++) begin
      chk("b2b_dout", dout, b2b[27-i]);
      chk("b2b_busy", busy, 1'b1);
      chk("b2b_done", done, (i == 13 || i == 27));
      if (i == 14) chk("b2b_state", state, 3'd1);
      if (i == 14) start = 1'b0;
      @(posedge clk); #1;
    end
    chk("b2b_end_busy", busy, 1'b0);
    chk("b2b_end_state", state, 3'd0);

    // Mid-frame asynchronous reset during DATA.
    @(negedge clk);
    start   = 1'b1;
    data_in = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    chk("pre_abort_state", state, 3'd2);
    chk("pre_abort_dout", dout, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_dout", dout, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_state", state, 3'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_frame(8'h3C, 14'b1101_00111100_0_0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
